deser_3t: RTL and testbench

- Serial-to-parallel deserializer: the one-to-many counterpart of the team's 3-input delayed OR reduction.
- Accepts a 1-bit serial stream under a valid/ready handshake and assembles WIDTH-bit words, LSB first.
- Presents each completed word on a registered parallel output with its own valid/ready handshake.
- Sits between a serial lab source (switch/bench stimulus) and the parallel gate-level datapath modules.

---
 rtl/deser_pkg.sv | 24 ++
 rtl/deser_3t_if.sv | 43 ++++
 rtl/deser_or_reduce.sv | 22 ++
 rtl/deser_3t.sv | 118 +++++++++++
 tb/tb_deser_3t.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/deser_pkg.sv
// Shared constants for the serial-to-parallel deserializer.
// DESER_PARITY_EN adds one trailing even-parity bit to every serial frame.
package deser_pkg;

  localparam int DEFAULT_WIDTH = 3;

`ifdef DESER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Serial bits per frame: data bits plus the optional parity bit.
  function automatic int frame_bits(input int width);
    return width + PAR_BITS;
  endfunction

endpackage

// File: rtl/deser_3t_if.sv
// Serial-in / parallel-out handshake bundle for deser_3t.
// DESER_PARITY_EN adds the m_perr signal.
interface deser_3t_if #(
  parameter int WIDTH = deser_pkg::DEFAULT_WIDTH
);
  logic             s_valid;
  logic             s_bit;
  logic             s_ready;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_any;
  logic             m_ready;
`ifdef DESER_PARITY_EN
  logic             m_perr;
`endif

  modport slave (
    input  s_valid,
    input  s_bit,
    input  m_ready,
    output s_ready,
    output m_valid,
    output m_data,
`ifdef DESER_PARITY_EN
    output m_perr,
`endif
    output m_any
  );

  modport master (
    output s_valid,
    output s_bit,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  m_data,
`ifdef DESER_PARITY_EN
    input  m_perr,
`endif
    input  m_any
  );

endinterface

// File: rtl/deser_or_reduce.sv
// WIDTH-input OR reduction feeding the m_any register (zero-delay form of
// the delayed OR gate used in gate-level sims).
module deser_or_reduce #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] in_i,
  output logic             any_o
);

  logic [WIDTH-1:0] chain;

  assign chain[0] = in_i[0];

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_or
      assign chain[gi] = chain[gi-1] | in_i[gi];
    end
  endgenerate

  assign any_o = chain[WIDTH-1];

endmodule

// File: rtl/deser_3t.sv
// Serial-to-parallel deserializer: LSB-first bits in, WIDTH-bit words out.
// DESER_PARITY_EN: each frame carries a trailing even-parity bit, flagged on m_perr.
module deser_3t
  import deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + PAR_BITS + 1)
) (
  input logic       clk,
  input logic       rst,
  deser_3t_if.slave bus
);

  localparam int NBITS = frame_bits(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_any_q, m_any_d;
  logic [WIDTH-1:0] ins_word;
  logic             word_any;
  logic             s_ready;
  logic             s_fire;
`ifdef DESER_PARITY_EN
  logic             m_perr_q, m_perr_d;
`endif

  assign s_ready = (state_q != ST_HOLD) || bus.m_ready;
  assign s_fire  = bus.s_valid && s_ready;

  // Current bit dropped into slot[count]; a parity bit (count==WIDTH) lands nowhere.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ins
      assign ins_word[gi] = (count_q == CNT_W'(gi)) ? bus.s_bit : shift_q[gi];
    end
  endgenerate

  deser_or_reduce #(.WIDTH(WIDTH)) u_or_reduce (
    .in_i  (ins_word),
    .any_o (word_any)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shift_d  = shift_q;
    m_data_d = m_data_q;
    m_any_d  = m_any_q;
`ifdef DESER_PARITY_EN
    m_perr_d = m_perr_q;
`endif
    case (state_q)
      ST_IDLE, ST_SHIFT: begin
        if (s_fire) begin
          if (count_q == CNT_W'(NBITS - 1)) begin
            state_d  = ST_HOLD;
            count_d  = '0;
            shift_d  = '0;
            m_data_d = ins_word;
            m_any_d  = word_any;
`ifdef DESER_PARITY_EN
            m_perr_d = bus.s_bit ^ (^shift_q);
`endif
          end else begin
            state_d = ST_SHIFT;
            count_d = count_q + CNT_W'(1);
            shift_d = ins_word;
          end
        end
      end
      ST_HOLD: begin
        // count is 0 here, so a simultaneous bit starts the next word bubble-free.
        if (bus.m_ready) begin
          if (bus.s_valid) begin
            state_d = ST_SHIFT;
            count_d = CNT_W'(1);
            shift_d = ins_word;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      shift_q  <= '0;
      m_data_q <= '0;
      m_any_q  <= 1'b0;
`ifdef DESER_PARITY_EN
      m_perr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      m_data_q <= m_data_d;
      m_any_q  <= m_any_d;
`ifdef DESER_PARITY_EN
      m_perr_q <= m_perr_d;
`endif
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = (state_q == ST_HOLD);
  assign bus.m_data  = m_data_q;
  assign bus.m_any   = m_any_q;
`ifdef DESER_PARITY_EN
  assign bus.m_perr  = m_perr_q;
`endif

endmodule

// File: tb/tb_deser_3t.sv
// Bench for deser_3t: WIDTH=3 and WIDTH=8 instances share stimulus and are
// compared every cycle against a queue-style frame model.
module tb_deser_3t;
  import deser_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  deser_3t_if #(.WIDTH(3)) bus3 ();
  deser_3t_if #(.WIDTH(8)) bus8 ();

  deser_3t #(.WIDTH(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
  deser_3t #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: collected frame bits and the word waiting downstream.
  int         mw [2] = '{3, 8};
  int         nb [2];
  logic [8:0] acc [2];
  bit         full [2];
  logic [7:0] word [2];
  bit         perr [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      nb[k]   = 0;
      acc[k]  = '0;
      full[k] = 1'b0;
      word[k] = '0;
      perr[k] = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit sv, input bit sb, input bit mr);
    logic       sr_o, mv_o, ma_o, pe_o;
    logic [7:0] md_o;
    bit         sr;
    int         nbits;
    @(negedge clk);
    rst          = r;
    bus3.s_valid = sv; bus3.s_bit = sb; bus3.m_ready = mr;
    bus8.s_valid = sv; bus8.s_bit = sb; bus8.m_ready = mr;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        sr_o = bus3.s_ready; mv_o = bus3.m_valid; ma_o = bus3.m_any;
        md_o = 8'(bus3.m_data);
`ifdef DESER_PARITY_EN
        pe_o = bus3.m_perr;
`else
        pe_o = 1'b0;
`endif
      end else begin
        sr_o = bus8.s_ready; mv_o = bus8.m_valid; ma_o = bus8.m_any;
        md_o = bus8.m_data;
`ifdef DESER_PARITY_EN
        pe_o = bus8.m_perr;
`else
        pe_o = 1'b0;
`endif
      end
      sr = !full[k] || mr;
      check_val($sformatf("w%0d_s_ready", mw[k]), 32'(sr_o), 32'(sr));
      check_val($sformatf("w%0d_m_valid", mw[k]), 32'(mv_o), 32'(full[k]));
      check_val($sformatf("w%0d_m_data", mw[k]), 32'(md_o), 32'(word[k]));
      check_val($sformatf("w%0d_m_any", mw[k]), 32'(ma_o), 32'(|word[k]));
      check_val($sformatf("w%0d_m_perr", mw[k]), 32'(pe_o), 32'(perr[k]));
      if (r) begin
        nb[k] = 0; acc[k] = '0; full[k] = 1'b0; word[k] = '0; perr[k] = 1'b0;
      end else begin
        if (full[k] && mr) full[k] = 1'b0;
        if (sv && sr) begin
          acc[k][nb[k]] = sb;
          nb[k]++;
          nbits = mw[k] + PAR_BITS;
          if (nb[k] == nbits) begin
            word[k] = 8'(acc[k] & ((9'd1 << mw[k]) - 9'd1));
            perr[k] = (PAR_BITS != 0) ? (acc[k][mw[k]] != (^word[k])) : 1'b0;
            full[k] = 1'b1;
            nb[k]   = 0;
            acc[k]  = '0;
          end
        end
      end
    end
  endtask

  initial begin
    bit b2b [6] = '{1, 1, 0, 0, 0, 0};
    logic [7:0] a5 = 8'hA5;
    rst = 1'b1;
    bus3.s_valid = 0; bus3.s_bit = 0; bus3.m_ready = 0;
    bus8.s_valid = 0; bus8.s_bit = 0; bus8.m_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);

    step(1, 0, 0, 0);
    check_val("reset_m_valid", 32'(bus3.m_valid), 32'd0);
    check_val("reset_m_data", 32'(bus3.m_data), 32'd0);

`ifndef DESER_PARITY_EN
    // Reset mid-word discards the partial bits.
    step(0, 1, 1, 1); step(0, 1, 0, 1);
    step(1, 1, 1, 1); step(1, 1, 0, 1);
    step(0, 1, 1, 1);
    check_val("midrst_m_valid", 32'(bus3.m_valid), 32'd0);
    check_val("midrst_m_data", 32'(bus3.m_data), 32'd0);
    step(0, 1, 0, 1); step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    check_val("fresh_m_valid", 32'(bus3.m_valid), 32'd1);
    check_val("fresh_m_data", 32'(bus3.m_data), 32'h5);
    check_val("fresh_m_any", 32'(bus3.m_any), 32'd1);
    step(0, 0, 0, 1);

    // Back-to-back words with no idle cycle.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, b2b[i], 1);
      if (i == 3) begin
        check_val("b2b_w1_data", 32'(bus3.m_data), 32'h3);
        check_val("b2b_w1_any", 32'(bus3.m_any), 32'd1);
        check_val("b2b_hold_s_ready", 32'(bus3.s_ready), 32'd1);
      end
    end
    step(0, 0, 0, 1);
    check_val("b2b_w2_valid", 32'(bus3.m_valid), 32'd1);
    check_val("b2b_w2_data", 32'(bus3.m_data), 32'h0);
    check_val("b2b_w2_any", 32'(bus3.m_any), 32'd0);

    // Backpressure: word 3'b110 held while the source keeps offering.
    step(0, 1, 0, 1); step(0, 1, 1, 1); step(0, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1'($urandom_range(1)), 0);
      check_val("bp_s_ready", 32'(bus3.s_ready), 32'd0);
      check_val("bp_m_data", 32'(bus3.m_data), 32'h6);
    end
    step(0, 1, 1, 1); step(0, 1, 0, 1); step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    check_val("bp_next_data", 32'(bus3.m_data), 32'h1);

    // Gaps in s_valid.
    step(0, 1, 1, 1); step(0, 0, 0, 1); step(0, 0, 1, 1);
    step(0, 1, 0, 1); step(0, 0, 0, 1); step(0, 1, 1, 1);
    step(0, 0, 0, 1);
    check_val("gap_m_data", 32'(bus3.m_data), 32'h5);
    step(0, 0, 0, 1);
    check_val("gap_once", 32'(bus3.m_valid), 32'd0);

    // WIDTH=8 instance.
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, a5[i], 1);
    step(0, 0, 0, 1);
    check_val("w8_a5_valid", 32'(bus8.m_valid), 32'd1);
    check_val("w8_a5_data", 32'(bus8.m_data), 32'hA5);
`else
    step(0, 1, 1, 1); step(0, 1, 1, 1); step(0, 1, 0, 1); step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    check_val("par_ok_data", 32'(bus3.m_data), 32'h3);
    check_val("par_ok_perr", 32'(bus3.m_perr), 32'd0);
    step(0, 1, 1, 1); step(0, 1, 1, 1); step(0, 1, 0, 1); step(0, 1, 1, 1);
    step(0, 0, 0, 1);
    check_val("par_bad_data", 32'(bus3.m_data), 32'h3);
    check_val("par_bad_perr", 32'(bus3.m_perr), 32'd1);
`endif

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(3) != 0),
           1'($urandom_range(1)), ($urandom_range(2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
